// File: rtl/bft_pkg.sv
// bft_pkg: shared types, LFSR taps and width helpers for the butterfly-fat-tree traffic PEs.
package bft_pkg;

    typedef enum logic [1:0] {
        MODE_COMPLEMENT,
        MODE_RANDOM,
        MODE_BITREV,
        MODE_NEIGHBOUR
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT,
        ST_DONE
    } state_e;

    // Fibonacci taps 16,14,13,11 as bit positions 15,13,12,10 of a left-shifting register
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic int calc_addr_w(input int num_leaves);
        return $clog2(num_leaves);
    endfunction

    function automatic int calc_seq_w(input int payload_sz, input int addr_w);
        return payload_sz - addr_w;
    endfunction

endpackage

// File: rtl/traffic_check.sv
// traffic_check: receive-side checker counting wrong-destination or out-of-order packets per source.
module traffic_check #(
    parameter int num_leaves = 8,
    parameter int addr_w = 3,
    parameter int seq_w = 4,
    parameter int p_sz = 11,
    parameter int addr = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [p_sz-1:0] bus_i,
    output logic [15:0]     err_count
);

    logic [seq_w-1:0]  exp_q [num_leaves];
    logic [seq_w-1:0]  exp_d [num_leaves];
    logic [15:0]       err_q;
    logic [15:0]       err_d;
    logic [addr_w-1:0] dst;
    logic [addr_w-1:0] src;
    logic [seq_w-1:0]  seq;
    logic              bad;

    always_comb begin
        dst = bus_i[p_sz-2 -: addr_w];
        src = bus_i[seq_w+addr_w-1 -: addr_w];
        seq = bus_i[seq_w-1:0];
        bad = (dst != addr_w'(addr)) || (seq != exp_q[src]);
        exp_d = exp_q;
        err_d = err_q;
        if (bus_i[p_sz-1]) begin
            // resynchronise on every packet so one gap yields one error, not a cascade
            exp_d[src] = seq + seq_w'(1);
            err_d = (bad && err_q != '1) ? err_q + 16'd1 : err_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            exp_q <= '{default: '0};
            err_q <= '0;
        end else begin
            exp_q <= exp_d;
            err_q <= err_d;
        end
    end

    assign err_count = err_q;

endmodule

// File: rtl/traffic_pe.sv
// traffic_pe: patterned, throttled, budgeted traffic source/sink for one gen_nw leaf.
// Define TRAFFIC_CHECK_EN to build the receive checker and the err_count port.
module traffic_pe
    import bft_pkg::*;
#(
    parameter int          num_leaves = 8,
    parameter int          payload_sz = calc_addr_w(num_leaves) + 4,
    parameter int          p_sz = 1 + calc_addr_w(num_leaves) + payload_sz,
    parameter int          addr = 0,
    parameter int          gap = 0,
    parameter int          max_packets = 0,
    parameter logic [15:0] seed = 16'hACE1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic [1:0]      mode,
    input  logic            resend,
    output logic [p_sz-1:0] bus_o,
    input  logic [p_sz-1:0] bus_i,
    output logic            done,
    output logic [31:0]     sent_count,
    output logic [31:0]     rcvd_count
`ifdef TRAFFIC_CHECK_EN
    ,
    output logic [15:0]     err_count
`endif
);

    localparam int addr_w = calc_addr_w(num_leaves);
    localparam int seq_w = calc_seq_w(payload_sz, addr_w);
    localparam logic [addr_w-1:0] my_addr = addr_w'(addr);

    state_e            state_q, state_d;
    logic [p_sz-1:0]   bus_q, bus_d;
    logic [31:0]       sent_q, sent_d;
    logic [31:0]       rcvd_q, rcvd_d;
    logic [seq_w-1:0]  seq_q, seq_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic [31:0]       gap_q, gap_d;
    logic [addr_w-1:0] dest;
    logic [addr_w-1:0] rev;
    logic [addr_w-1:0] rnd;

    always_comb begin
        rev = '0;
        for (int i = 0; i < addr_w; i++) rev[i] = my_addr[addr_w-1-i];
        rnd = lfsr_q[addr_w-1:0];
        case (mode_e'(mode))
            MODE_COMPLEMENT: dest = ~my_addr;
            MODE_RANDOM:     dest = (rnd == my_addr) ? rnd + addr_w'(1) : rnd;
            MODE_BITREV:     dest = rev;
            default:         dest = my_addr + addr_w'(1);
        endcase
    end

    always_comb begin
        state_d = state_q;
        bus_d = bus_q;
        sent_d = sent_q;
        seq_d = seq_q;
        lfsr_d = lfsr_q;
        gap_d = gap_q;
        rcvd_d = (bus_i[p_sz-1] && rcvd_q != '1) ? rcvd_q + 32'd1 : rcvd_q;
        case (state_q)
            ST_IDLE: if (enable) begin
                bus_d = {1'b1, dest, my_addr, seq_q};
                lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
                state_d = ST_SEND;
            end
            // resend keeps bus_q untouched, so a retry can never pick up a new mode
            ST_SEND: if (!resend) begin
                bus_d = '0;
                sent_d = (sent_q != '1) ? sent_q + 32'd1 : sent_q;
                seq_d = seq_q + seq_w'(1);
                gap_d = 32'(gap - 1);
                state_d = (max_packets != 0 && sent_d == 32'(max_packets)) ? ST_DONE :
                          (gap > 0) ? ST_WAIT : ST_IDLE;
            end
            ST_WAIT: begin
                gap_d = gap_q - 32'd1;
                state_d = (gap_q == 32'd0) ? ST_IDLE : ST_WAIT;
            end
            default: bus_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            bus_q <= '0;
            sent_q <= '0;
            rcvd_q <= '0;
            seq_q <= '0;
            lfsr_q <= seed;
            gap_q <= '0;
        end else begin
            state_q <= state_d;
            bus_q <= bus_d;
            sent_q <= sent_d;
            rcvd_q <= rcvd_d;
            seq_q <= seq_d;
            lfsr_q <= lfsr_d;
            gap_q <= gap_d;
        end
    end

    assign bus_o = bus_q;
    assign done = (state_q == ST_DONE);
    assign sent_count = sent_q;
    assign rcvd_count = rcvd_q;

`ifdef TRAFFIC_CHECK_EN
    traffic_check #(
        .num_leaves(num_leaves),
        .addr_w(addr_w),
        .seq_w(seq_w),
        .p_sz(p_sz),
        .addr(addr)
    ) u_check (
        .clk(clk),
        .reset(reset),
        .bus_i(bus_i),
        .err_count(err_count)
    );
`else
    logic unused_bus_i;
    assign unused_bus_i = ^bus_i[p_sz-2:0];
`endif

endmodule

// File: tb/tb_traffic_pe.sv
// tb_traffic_pe: directed plus randomized bench for traffic_pe against a behavioural model.
module tb_traffic_pe;

    logic        clk = 0;
    logic        reset;
    logic        en_a, en_b, en_c;
    logic [1:0]  mode_a, mode_b, mode_c;
    logic        rs_a, rs_b, rs_c;
    logic [10:0] bus_i_a;
    logic [10:0] bus_o_a, bus_o_b, bus_o_c;
    logic        done_a, done_b, done_c;
    logic [31:0] sent_a, sent_b, sent_c;
    logic [31:0] rcvd_a, rcvd_b, rcvd_c;
`ifdef TRAFFIC_CHECK_EN
    logic [15:0] err_a, err_b, err_c;
`endif

    int checks = 0;
    int failures = 0;
    int seq_m, sent_m, rcvd_m, err_m, lfsr_m;
    int exp_tab[8];

    always #5 clk = ~clk;

    traffic_pe #(.addr(2)) dut_a (
        .clk(clk), .reset(reset), .enable(en_a), .mode(mode_a), .resend(rs_a),
        .bus_o(bus_o_a), .bus_i(bus_i_a), .done(done_a), .sent_count(sent_a), .rcvd_count(rcvd_a)
`ifdef TRAFFIC_CHECK_EN
        , .err_count(err_a)
`endif
    );

    traffic_pe #(.addr(5), .gap(3), .max_packets(2)) dut_b (
        .clk(clk), .reset(reset), .enable(en_b), .mode(mode_b), .resend(rs_b),
        .bus_o(bus_o_b), .bus_i(11'd0), .done(done_b), .sent_count(sent_b), .rcvd_count(rcvd_b)
`ifdef TRAFFIC_CHECK_EN
        , .err_count(err_b)
`endif
    );

    traffic_pe #(.addr(0), .seed(16'hACE1)) dut_c (
        .clk(clk), .reset(reset), .enable(en_c), .mode(mode_c), .resend(rs_c),
        .bus_o(bus_o_c), .bus_i(11'd0), .done(done_c), .sent_count(sent_c), .rcvd_count(rcvd_c)
`ifdef TRAFFIC_CHECK_EN
        , .err_count(err_c)
`endif
    );

    function automatic int lfsr_next(input int l);
        int fb = ((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 1;
        return ((l << 1) | fb) & 'hFFFF;
    endfunction

    function automatic int dest_of(input int m, input int a, input int l);
        int d;
        case (m)
            0: d = 7 - a;
            1: begin
                d = l % 8;
                if (d == a) d = (d + 1) % 8;
            end
            2: d = ((a & 1) << 2) | (a & 2) | ((a >> 2) & 1);
            default: d = (a + 1) % 8;
        endcase
        return d;
    endfunction

    function automatic logic [10:0] pkt(input int d, input int a, input int s, input bit v = 1);
        return {v, 3'(d), 3'(a), 4'(s)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rx(input int d, input int src, input int sq, input bit v);
        bus_i_a = pkt(d, src, sq, v);
        if (v) begin
            rcvd_m++;
            if (d != 2 || sq != exp_tab[src]) err_m++;
            exp_tab[src] = (sq + 1) % 16;
        end
        tick(1);
        bus_i_a = '0;
        chk("rx_rcvd", rcvd_a, rcvd_m);
`ifdef TRAFFIC_CHECK_EN
        chk("rx_err", err_a, err_m);
`endif
    endtask

    task automatic send_one(input int m, input int retries);
        logic [10:0] want;
        en_a = 1;
        mode_a = 2'(m);
        rs_a = 0;
        want = pkt(dest_of(m, 2, lfsr_m), 2, seq_m);
        lfsr_m = lfsr_next(lfsr_m);
        tick(1);
        chk("a_pkt", bus_o_a, want);
        if (sent_m == 0 && m == 0) chk("a_first_lit", bus_o_a, 11'b1_101_010_0000);
        rs_a = 1;
        for (int r = 0; r < retries; r++) begin
            mode_a = 2'($urandom_range(0, 3));
            en_a = 1'($urandom_range(0, 1));
            tick(1);
            chk("a_hold_pkt", bus_o_a, want);
            chk("a_hold_sent", sent_a, sent_m);
        end
        rs_a = 0;
        tick(1);
        sent_m++;
        seq_m = (seq_m + 1) % 16;
        chk("a_accept_sent", sent_a, sent_m);
        chk("a_accept_bus", bus_o_a, 0);
    endtask

    initial begin
        int sq, src, lfsr_c, seq_c;
        reset = 1;
        {en_a, en_b, en_c, rs_a, rs_b, rs_c} = '0;
        {mode_a, mode_b, mode_c} = '0;
        bus_i_a = '0;
        seq_m = 0; sent_m = 0; rcvd_m = 0; err_m = 0; lfsr_m = 'hACE1;
        foreach (exp_tab[i]) exp_tab[i] = 0;
        tick(3);
        chk("rst_bus_a", bus_o_a, 0);
        chk("rst_done_a", done_a, 0);
        chk("rst_sent_a", sent_a, 0);
        chk("rst_rcvd_a", rcvd_a, 0);
        chk("rst_bus_b", bus_o_b, 0);
        chk("rst_done_b", done_b, 0);
`ifdef TRAFFIC_CHECK_EN
        chk("rst_err_a", err_a, 0);
`endif
        reset = 0;
        tick(2);
        chk("idle_no_enable", bus_o_a, 0);

        // receive: src 3 seq 0,1,3 then a misrouted packet, then random traffic
        rx(2, 3, 0, 1);
        rx(2, 3, 1, 1);
        rx(2, 3, 3, 1);
        rx(6, 3, 4, 1);
        for (int k = 0; k < 30; k++) begin
            src = $urandom_range(0, 7);
            sq = $urandom_range(0, 1) ? exp_tab[src] : $urandom_range(0, 15);
            rx($urandom_range(0, 3) == 0 ? $urandom_range(0, 7) : 2, src, sq, 1'($urandom_range(0, 2) != 0));
        end

        // transmit on dut_a
        send_one(0, 0);
        send_one(0, 0);
        send_one(1, 3);
        en_a = 0;
        tick(2);
        chk("a_idle_bus", bus_o_a, 0);
        chk("a_idle_sent", sent_a, sent_m);
        for (int k = 0; k < 24; k++) send_one($urandom_range(0, 3), $urandom_range(0, 2));
        en_a = 0;

        // gap=3, budget 2, resend on the budget-hitting cycle
        en_b = 1;
        mode_b = 3;
        for (int t = 1; t <= 12; t++) begin
            rs_b = (t == 7);
            tick(1);
            chk("b_valid", bus_o_b[10], (t == 1 || t == 6 || t == 7));
            chk("b_done", done_b, (t >= 8));
            if (t == 1) chk("b_pkt0", bus_o_b, pkt(6, 5, 0));
            if (t == 6 || t == 7) chk("b_pkt1", bus_o_b, pkt(6, 5, 1));
            if (t == 7) chk("b_sent_hold", sent_b, 1);
        end
        rs_b = 0;
        chk("b_sent_final", sent_b, 2);

        // random mode from addr 0 over 100 packets
        lfsr_c = 'hACE1;
        seq_c = 0;
        en_c = 1;
        mode_c = 1;
        for (int k = 0; k < 100; k++) begin
            tick(1);
            chk("c_pkt", bus_o_c, pkt(dest_of(1, 0, lfsr_c), 0, seq_c));
            chk("c_dest_nonzero", (bus_o_c[9:7] != 3'd0), 1);
            lfsr_c = lfsr_next(lfsr_c);
            seq_c = (seq_c + 1) % 16;
            tick(1);
        end
        chk("c_sent", sent_c, 100);
        en_c = 0;

        // reset in the middle of SEND
        en_a = 1;
        mode_a = 0;
        tick(1);
        chk("a_pre_rst_valid", bus_o_a[10], 1);
        reset = 1;
        tick(1);
        chk("a_rst_bus", bus_o_a, 0);
        chk("a_rst_sent", sent_a, 0);
        chk("a_rst_rcvd", rcvd_a, 0);
        chk("b_rst_done", done_b, 0);
        reset = 0;
        seq_m = 0; sent_m = 0; lfsr_m = 'hACE1;
        send_one(0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
